prefix_or_search: RTL and testbench
===================================

# prefix_or_search

Sequential inverse of the case-selected prefix-OR path. The forward path computes o = |b[a-1:0], with a = 0 giving o = 0. This block accepts a 27-bit vector b and returns the smallest selector a for which that prefix-OR is 1, or reports that no such selector exists. It scans one bit per cycle, LSB first, behind valid/ready handshakes on both sides, and sits next to the selector logic as its search engine.

## Interface
Parameters:
- W, 27, width of the searched vector. Legal range 1..(2**AW - 1).
- AW, 5, width of the selector result.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- clr  input  1  synchronous abort; returns the block to IDLE from any state.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  W  vector b to search.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sel  output  AW  smallest a in 1..W with |b[a-1:0] = 1; 0 if none.
- out_found  output  1  1 if any bit of b is set.

## Operation
- State machine with three states: IDLE, SCAN, DONE.
  - IDLE: in_ready = 1, out_valid = 0. On in_valid & in_ready: capture in_data into an internal register, clear the bit counter cnt (AW bits), go to SCAN.
  - SCAN: test captured bit [cnt].
    - Bit is 1: out_sel <= cnt + 1, out_found <= 1, go to DONE.
    - Bit is 0 and cnt == W-1: out_sel <= 0, out_found <= 0, go to DONE.
    - Otherwise: cnt <= cnt + 1.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE. Both are decoded from state, with no combinational path from any input.
- out_sel and out_found are registered. They hold stable in DONE until the transfer completes, and keep their last values in IDLE and SCAN.
- Width rule: cnt + 1 is computed in AW bits. W <= 2**AW - 1 guarantees no wrap (W = 27 gives a maximum out_sel of 27).
- in_data changes outside an IDLE accept are ignored. The captured copy does not change during SCAN.
- clr takes priority over every transition and over the handshakes. The next state is IDLE, the pending result is dropped, and out_sel / out_found keep their values.
- Reset (rst_n low, any time including mid-SCAN or in DONE) clears everything immediately:
  - state = IDLE, cnt = 0, captured data = 0.
  - out_sel = 0, out_found = 0, out_valid = 0, in_ready = 1.

## Timing
- Accept edge is T. Lowest set bit is at position p.
  - Bit p is tested in cycle T+1+p.
  - out_valid rises after edge T+2+p, so latency is p+2 edges from accept.
- All-zero vector: W scan cycles, so out_valid rises after edge T+W+1 (T+28 for W = 27).
- Output transfer at edge U (out_valid & out_ready): in_ready = 1 in the following cycle. The next accept is at edge U+1 at the earliest, so there is one bubble cycle between jobs.
- No result is lost under backpressure. DONE holds indefinitely while out_ready = 0.
- in_valid asserted outside IDLE is not accepted. The producer must hold the request until it sees in_ready.

## Test plan
- Accept b = 27'h0000001 at edge T: out_valid rises after T+2 with out_sel = 1, out_found = 1. Transfer with out_ready = 1, then in_ready = 1 the next cycle.
- b = 27'h4000000: out_sel = 27, out_found = 1, out_valid rises after T+28. b = 27'h0000000: out_sel = 0, out_found = 0, also after T+28.
- b = 27'h0000F00: out_sel = 9 after T+10. Cross-check against the forward mapping for a in 0..27: |b[a-1:0] = 0 for every a < 9 and = 1 for a = 9.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE. out_valid stays 1, out_sel / out_found stay stable, in_ready = 0, and in_valid pulses are ignored. Then release out_ready, the transfer occurs, and IDLE follows.
- Mid-scan disturbance, three cases:
  - Assert clr at cycle T+5 while scanning b = 27'h0100000: IDLE next cycle, no out_valid.
  - Pulse rst_n low asynchronously mid-scan: all outputs go to reset values immediately.
  - After either case, a new request b = 27'h0000002 returns out_sel = 2.
- Back-to-back random vectors (≥1000) with random in_valid / out_ready stalls: every out_sel equals (index of lowest set bit + 1) or 0, and no job is dropped or duplicated.

Source files
------------

// File: rtl/prefix_or_search.sv
// Sequential search for the smallest selector a with |b[a-1:0] = 1.
// Scans the captured vector LSB first, one bit per cycle, behind valid/ready handshakes.
module prefix_or_search #(
  parameter int W  = 27,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sel,
  output logic          out_found
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(W - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_inc;
  logic [W-1:0]  data;
  logic          primed;

  // W <= 2**AW - 1, so the increment never wraps.
  assign cnt_inc = cnt + AW'(1);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: every register here is assigned with <= so all of them update together
  // from the values that held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      data      <= '0;
      primed    <= 1'b0;
      out_sel   <= '0;
      out_found <= 1'b0;
    end else if (clr) begin
      state  <= IDLE;
      primed <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data   <= in_data;
            cnt    <= '0;
            primed <= 1'b0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          // The first SCAN cycle only arms the scan; bit p is tested p+1 cycles later.
          if (!primed) begin
            primed <= 1'b1;
          end else if (data[cnt]) begin
            out_sel   <= cnt_inc;
            out_found <= 1'b1;
            primed    <= 1'b0;
            state     <= DONE;
          end else if (cnt == LAST) begin
            out_sel   <= '0;
            out_found <= 1'b0;
            primed    <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prefix_or_search.sv
// Directed and randomized checks of prefix_or_search against a forward prefix-OR model.
module tb_prefix_or_search;

  localparam int W      = 27;
  localparam int AW     = 5;
  localparam int NJOBS  = 1000;
  localparam int BUDGET = 60000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_sel;
  logic          out_found;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_acc = 0;

  logic [AW:0] q[$];

  prefix_or_search #(.W(W), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_found (out_found)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Forward mapping: smallest a in 1..W whose prefix-OR |b[a-1:0] is 1, else 0.
  function automatic logic [AW:0] model(input logic [W-1:0] b);
    logic [31:0] m;
    for (int a = 1; a <= W; a++) begin
      m = (32'd1 << a) - 32'd1;
      if (|(b & m[W-1:0])) return {1'b1, AW'(a)};
    end
    return '0;
  endfunction

  task automatic send(input logic [W-1:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("send_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    t_acc    = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_lat"}, 32'(cyc - t_acc), 32'(exp_lat));
  endtask

  task automatic get(input string tag, input int exp_sel, input logic exp_found, input int exp_lat);
    out_ready = 1'b1;
    wait_valid(tag, exp_lat);
    check({tag, "_sel"}, 32'(out_sel), 32'(exp_sel));
    check({tag, "_found"}, 32'(out_found), 32'(exp_found));
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(in_ready), 1);
    check({tag, "_vdrop"}, 32'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    #2;
    check("rst_sel", 32'(out_sel), 0);
    check("rst_found", 32'(out_found), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    send(27'h0000001);  get("b1", 1, 1'b1, 2);
    send(27'h4000000);  get("b26", 27, 1'b1, 28);
    send(27'h0000000);  get("zero", 0, 1'b0, 28);
    send(27'h0000F00);  get("f00", 9, 1'b1, 10);
    check("f00_model", 32'(model(27'h0000F00)), 32'({1'b1, 5'd9}));

    // Backpressure: result held, requests ignored.
    send(27'h0000010);
    out_ready = 1'b0;
    wait_valid("bp", 6);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_data  = 27'h0000001;
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_sel", 32'(out_sel), 5);
      check("bp_hold_found", 32'(out_found), 1);
      check("bp_hold_ready", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_ready", 32'(in_ready), 1);
    check("bp_rel_valid", 32'(out_valid), 0);
    out_ready = 1'b0;
    send(27'h0000002);  get("bp_next", 2, 1'b1, 3);

    // clr at edge T+5 while scanning bit 20.
    send(27'h0100000);
    repeat (4) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_ready", 32'(in_ready), 1);
    check("clr_valid", 32'(out_valid), 0);
    check("clr_sel_kept", 32'(out_sel), 2);
    seen = 0;
    out_ready = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("clr_no_result", 32'(seen), 0);
    send(27'h0000002);  get("clr_next", 2, 1'b1, 3);

    // Asynchronous reset mid-scan.
    send(27'h0100000);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(out_sel), 0);
    check("arst_found", 32'(out_found), 0);
    check("arst_valid", 32'(out_valid), 0);
    check("arst_ready", 32'(in_ready), 1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(27'h0000002);  get("arst_next", 2, 1'b1, 3);

    // Random back-to-back jobs with stalls on both sides.
    fork
      begin : producer
        int n = 0;
        int cy = 0;
        logic rdy;
        logic vld;
        logic [W-1:0] d;
        while (n < NJOBS && cy < BUDGET) begin
          if (!in_valid && $urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 7) == 0) in_data = '0;
            else in_data = (W'($urandom) | W'(1)) << $urandom_range(0, W - 1);
            in_valid = 1'b1;
          end
          rdy = in_ready;
          vld = in_valid;
          d   = in_data;
          @(posedge clk); #1; cy++;
          if (rdy && vld) begin
            q.push_back(model(d));
            n++;
            in_valid = 1'b0;
          end
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int got_n = 0;
        int cy = 0;
        logic r;
        logic v;
        logic [AW:0] res;
        logic [AW:0] e;
        while (got_n < NJOBS && cy < BUDGET) begin
          r = ($urandom_range(0, 3) != 0);
          out_ready = r;
          v   = out_valid;
          res = {out_found, out_sel};
          @(posedge clk); #1; cy++;
          if (v && r) begin
            if (q.size() == 0) check("rnd_extra", 32'(q.size()), 1);
            else begin
              e = q.pop_front();
              check("rnd_res", 32'(res), 32'(e));
            end
            got_n++;
          end
        end
        out_ready = 1'b0;
        check("rnd_count", 32'(got_n), NJOBS);
      end
    join
    check("rnd_left", 32'(q.size()), 0);
    repeat (40) @(posedge clk);
    #1;
    check("rnd_quiet", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
